// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode codes, FSM states
// and the per-bit next-value select.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROL   = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;
    localparam logic [2:0] MODE_BURST = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Source of each bit slice's next value.
    typedef enum logic [2:0] {
        SEL_SELF,
        SEL_LEFT,
        SEL_RIGHT,
        SEL_D,
        SEL_RST
    } sel_t;

endpackage

// File: rtl/universal_shift_reg_if.sv
// Control/data bundle of the universal shift register. Optional PAR output is
// present only when USR_PARITY_EN is defined.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int AW = $clog2(WIDTH) + 1;

    logic             i_en;
    logic [2:0]       i_mode;
    logic [WIDTH-1:0] i_d;
    logic             i_sin_l;
    logic             i_sin_r;
    logic [AW-1:0]    i_amt;
    logic [WIDTH-1:0] o_q;
    logic             o_sout_l;
    logic             o_sout_r;
    logic             o_busy;
    logic             o_done;
`ifdef USR_PARITY_EN
    logic             o_par;
`endif

    modport master (
        output i_en, i_mode, i_d, i_sin_l, i_sin_r, i_amt,
`ifdef USR_PARITY_EN
        input  o_par,
`endif
        input  o_q, o_sout_l, o_sout_r, o_busy, o_done
    );

    modport slave (
        input  i_en, i_mode, i_d, i_sin_l, i_sin_r, i_amt,
`ifdef USR_PARITY_EN
        output o_par,
`endif
        output o_q, o_sout_l, o_sout_r, o_busy, o_done
    );

endinterface

// File: rtl/usr_bit_cell.sv
// One bit slice: next-value mux plus a flop with synchronous reset and enable.
// With USR_PARITY_EN the mux output is exported so the top can track parity.
module usr_bit_cell
    import usr_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  sel_t i_sel,
    input  logic i_left,
    input  logic i_right,
    input  logic i_d,
`ifdef USR_PARITY_EN
    output logic o_nxt,
`endif
    output logic o_q
);

    logic r_q;
    logic w_nxt;

    // NOTE: default assigned first so every path drives w_nxt; no latch.
    always_comb begin
        w_nxt = r_q;
        case (i_sel)
            SEL_LEFT:  w_nxt = i_left;
            SEL_RIGHT: w_nxt = i_right;
            SEL_D:     w_nxt = i_d;
            SEL_RST:   w_nxt = RST_BIT;
            default:   w_nxt = r_q;
        endcase
    end

    // NOTE: reset is synchronous and checked before enable, so it always wins.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_q <= RST_BIT;
        else if (i_en)
            r_q <= w_nxt;
    end

    assign o_q = r_q;
`ifdef USR_PARITY_EN
    assign o_nxt = w_nxt;
`endif

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register with hold/shift/rotate/load/clear and a
// multi-cycle burst rotate with BUSY/DONE. Optional PAR output: USR_PARITY_EN.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    universal_shift_reg_if.slave  bus
);

    localparam int AW = $clog2(WIDTH) + 1;

    state_t           r_state, w_state_nxt;
    logic [AW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_done, w_done_nxt;
    logic [AW-1:0]    w_amount;
    sel_t             w_sel;
    logic             w_fill_l;
    logic             w_fill_r;
    logic [WIDTH-1:0] w_q;

    // Amounts above WIDTH wrap; exactly WIDTH is a full-circle burst.
    assign w_amount = (bus.i_amt > AW'(WIDTH)) ? (bus.i_amt % AW'(WIDTH)) : bus.i_amt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_sel       = SEL_SELF;
        w_fill_l    = w_q[WIDTH-1];
        w_fill_r    = w_q[0];
        if (bus.i_en) begin
            case (r_state)
                ST_IDLE: begin
                    case (bus.i_mode)
                        MODE_SHL: begin
                            w_sel    = SEL_LEFT;
                            w_fill_l = bus.i_sin_l;
                        end
                        MODE_SHR: begin
                            w_sel    = SEL_RIGHT;
                            w_fill_r = bus.i_sin_r;
                        end
                        MODE_ROL:   w_sel = SEL_LEFT;
                        MODE_ROR:   w_sel = SEL_RIGHT;
                        MODE_LOAD:  w_sel = SEL_D;
                        MODE_CLEAR: w_sel = SEL_RST;
                        MODE_BURST: begin
                            if (w_amount == '0) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_cnt_nxt   = w_amount;
                                w_state_nxt = ST_BURST;
                            end
                        end
                        default: w_sel = SEL_SELF;
                    endcase
                end
                ST_BURST: begin
                    w_sel     = SEL_LEFT;
                    w_cnt_nxt = r_cnt - AW'(1);
                    if (r_cnt == AW'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments keep all state flops updating together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef USR_PARITY_EN
    logic [WIDTH-1:0] w_nxt;
    logic             r_par;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_left;
        logic w_right;
        if (i == 0) begin : g_lsb
            assign w_left = w_fill_l;
        end else begin : g_mid_l
            assign w_left = w_q[i-1];
        end
        if (i == WIDTH - 1) begin : g_msb
            assign w_right = w_fill_r;
        end else begin : g_mid_r
            assign w_right = w_q[i+1];
        end
        usr_bit_cell #(
            .RST_BIT (RESET_VAL[i])
        ) u_cell (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_en    (bus.i_en),
            .i_sel   (w_sel),
            .i_left  (w_left),
            .i_right (w_right),
            .i_d     (bus.i_d[i]),
`ifdef USR_PARITY_EN
            .o_nxt   (w_nxt[i]),
`endif
            .o_q     (w_q[i])
        );
    end

`ifdef USR_PARITY_EN
    // Parity of the value Q is about to take, so PAR and Q change together.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_par <= ^RESET_VAL;
        else if (bus.i_en)
            r_par <= ^w_nxt;
    end
    assign bus.o_par = r_par;
`endif

    assign bus.o_q      = w_q;
    assign bus.o_sout_l = w_q[WIDTH-1];
    assign bus.o_sout_r = w_q[0];
    assign bus.o_busy   = (r_state == ST_BURST);
    assign bus.o_done   = r_done;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (WIDTH=8, RESET_VAL=A5).
module tb_universal_shift_reg;
    import usr_pkg::*;

    localparam int         WIDTH = 8;
    localparam logic [7:0] RV    = 8'hA5;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    universal_shift_reg_if #(.WIDTH(WIDTH)) usr_bus ();

    universal_shift_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RV)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (usr_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] mode, input logic [7:0] d);
        usr_bus.i_en   = 1'b1;
        usr_bus.i_mode = mode;
        usr_bus.i_d    = d;
        step();
    endtask

    // Starts a burst, optionally stalls EN for stall_n cycles from loop index
    // stall_at, and checks BUSY length, DONE count and final Q.
    task automatic run_burst(input string tag, input logic [3:0] amt,
                             input int stall_at, input int stall_n,
                             input int exp_busy, input logic [7:0] exp_q);
        int busy_cnt = 0;
        int done_cnt = 0;
        logic [7:0] q_done = '0;
        usr_bus.i_en   = 1'b1;
        usr_bus.i_mode = MODE_BURST;
        usr_bus.i_amt  = amt;
        step();
        usr_bus.i_mode = MODE_HOLD;
        for (int k = 0; k < 32; k++) begin
            if (usr_bus.o_busy) busy_cnt++;
            if (usr_bus.o_done) begin
                done_cnt++;
                q_done = usr_bus.o_q;
                break;
            end
            usr_bus.i_en = !(k >= stall_at && k < stall_at + stall_n);
            step();
        end
        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_busy"}, busy_cnt, exp_busy);
        check({tag, "_q"}, q_done, exp_q);
        usr_bus.i_en = 1'b1;
        step();
        check({tag, "_done_clr"}, usr_bus.o_done, 1'b0);
    endtask

    initial begin
        rst             = 1'b1;
        usr_bus.i_en    = 1'b1;
        usr_bus.i_mode  = MODE_LOAD;
        usr_bus.i_d     = 8'hFF;
        usr_bus.i_sin_l = 1'b0;
        usr_bus.i_sin_r = 1'b0;
        usr_bus.i_amt   = '0;
        step();
        check("rst_q", usr_bus.o_q, 8'hA5);
        check("rst_busy", usr_bus.o_busy, 1'b0);
        check("rst_done", usr_bus.o_done, 1'b0);
`ifdef USR_PARITY_EN
        check("rst_par", usr_bus.o_par, 1'b0);
`endif
        rst = 1'b0;

        op(MODE_LOAD, 8'h81);
        check("load", usr_bus.o_q, 8'h81);
        usr_bus.i_sin_l = 1'b1;
        op(MODE_SHL, 8'h00);
        check("shl_q", usr_bus.o_q, 8'h03);
        check("shl_sout_l", usr_bus.o_sout_l, 1'b0);
        check("shl_sout_r", usr_bus.o_sout_r, 1'b1);
        usr_bus.i_sin_r = 1'b1;
        op(MODE_SHR, 8'h00);
        check("shr_q", usr_bus.o_q, 8'h81);

        op(MODE_LOAD, 8'h81);
        op(MODE_ROR, 8'h00);
        check("ror", usr_bus.o_q, 8'hC0);
        op(MODE_ROL, 8'h00);
        check("rol", usr_bus.o_q, 8'h81);
        op(MODE_HOLD, 8'h3C);
        check("hold", usr_bus.o_q, 8'h81);
        usr_bus.i_en   = 1'b0;
        usr_bus.i_mode = MODE_LOAD;
        step();
        check("en_low", usr_bus.o_q, 8'h81);
        op(MODE_CLEAR, 8'h00);
        check("clear", usr_bus.o_q, 8'hA5);

        op(MODE_LOAD, 8'h01);
        run_burst("b3", 4'd3, 99, 0, 3, 8'h08);
        op(MODE_LOAD, 8'h01);
        run_burst("b3s", 4'd3, 1, 2, 5, 8'h08);
        op(MODE_LOAD, 8'h5A);
        run_burst("b0", 4'd0, 99, 0, 0, 8'h5A);
        op(MODE_LOAD, 8'h01);
        run_burst("b9", 4'd9, 99, 0, 1, 8'h02);
        op(MODE_LOAD, 8'h01);
        run_burst("b8", 4'd8, 99, 0, 8, 8'h01);

        // DONE self-clears even with EN low.
        op(MODE_LOAD, 8'h11);
        usr_bus.i_mode = MODE_BURST;
        usr_bus.i_amt  = 4'd0;
        step();
        check("b0_done_pulse", usr_bus.o_done, 1'b1);
        usr_bus.i_en = 1'b0;
        step();
        check("done_clr_en0", usr_bus.o_done, 1'b0);

        // Reset in the middle of a burst aborts it with no DONE.
        op(MODE_LOAD, 8'h01);
        usr_bus.i_mode = MODE_BURST;
        usr_bus.i_amt  = 4'd5;
        step();
        usr_bus.i_mode = MODE_HOLD;
        step();
        check("mid_q", usr_bus.o_q, 8'h02);
        rst = 1'b1;
        step();
        check("abort_q", usr_bus.o_q, 8'hA5);
        check("abort_busy", usr_bus.o_busy, 1'b0);
        check("abort_done", usr_bus.o_done, 1'b0);
        rst = 1'b0;
        step();
        check("abort_done2", usr_bus.o_done, 1'b0);
        check("abort_busy2", usr_bus.o_busy, 1'b0);

`ifdef USR_PARITY_EN
        op(MODE_LOAD, 8'h07);
        check("par_07", usr_bus.o_par, 1'b1);
        op(MODE_LOAD, 8'h03);
        check("par_03", usr_bus.o_par, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor to the single-bit D storage element: a WIDTH-bit edge-triggered register with enable, synchronous reset and mode-selected update.
- Supported updates: hold, shift, rotate, parallel load, clear, and a multi-cycle burst rotate with BUSY/DONE handshake.
- Serves as the generic storage/shift primitive for serial links, LFSR-style datapaths and bit-serial arithmetic in the course projects.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VAL, 0, value loaded into Q on reset and by MODE=CLEAR; WIDTH bits.
- AW, $clog2(WIDTH)+1, width of AMT and of the burst counter (derived; not overridden).

Ports:
- CLK     in   1      rising-edge clock
- RST     in   1      synchronous reset, active-high
- EN      in   1      clock enable; 0 = hold everything, including burst progress
- MODE    in   3      operation select; sampled only in IDLE with EN=1
- D       in   WIDTH  parallel load data
- SIN_L   in   1      serial input entering bit 0 on shift-left
- SIN_R   in   1      serial input entering bit WIDTH-1 on shift-right
- AMT     in   AW     burst rotate amount; sampled with MODE=BURST
- Q       out  WIDTH  register contents
- SOUT_L  out  1      Q[WIDTH-1], combinational from register
- SOUT_R  out  1      Q[0], combinational from register
- BUSY    out  1      high while a burst is in progress
- DONE    out  1      one-cycle pulse when a burst completes

Behaviour:
- Reset state, when RST=1 at a CLK edge: Q=RESET_VAL, BUSY=0, DONE=0, state=IDLE, counter=0. RST overrides EN, MODE and any burst in progress; a burst is aborted with no DONE pulse.
- Latency: Q reflects the op one CLK edge after it is sampled. All outputs are registered except SOUT_L/SOUT_R.
- MODE codes:
  - 000 HOLD
  - 001 SHL: Q <= {Q[W-2:0],SIN_L}
  - 010 SHR: Q <= {SIN_R,Q[W-1:1]}
  - 011 ROL: Q <= {Q[W-2:0],Q[W-1]}
  - 100 ROR: Q <= {Q[0],Q[W-1:1]}
  - 101 LOAD: Q <= D
  - 110 CLEAR: Q <= RESET_VAL
  - 111 BURST
- FSM states: IDLE, BURST.
- IDLE, EN=1, MODE!=111: apply op; stay IDLE.
- IDLE, EN=1, MODE=111:
  - AMT=0: Q unchanged; DONE=1 next cycle; stay IDLE.
  - AMT>WIDTH: amount is taken as AMT mod WIDTH, then the AMT=0 rule applies if the result is 0.
  - Otherwise: counter <= amount; go to BURST; BUSY=1 from the next cycle.
- BURST, EN=1: Q <= ROL(Q); counter decrements. When the counter reaches 1 and that rotate is performed, go to IDLE, BUSY=0 and DONE=1 on the same edge. BUSY is high for exactly `amount` enabled cycles.
- BURST, EN=0: Q, counter and state hold; BUSY stays 1.
- MODE, D, SIN_L/R and AMT are ignored while in BURST.
- DONE is high for exactly one cycle and cleared on the following edge regardless of EN. A new op may be issued in the cycle DONE is high, because the FSM is in IDLE.
- IDLE with EN=0: everything holds; DONE still self-clears.

Optional Feature:
- Macro: USR_PARITY_EN.
- Defined: extra output PAR (1 bit) = XOR of all Q bits, registered alongside Q, so it matches Q in the same cycle. Reset value is the parity of RESET_VAL.
- Undefined: no PAR port, no parity logic.

Decomposition:
- Package usr_pkg holds:
  - mode localparams MODE_HOLD..MODE_BURST (3-bit)
  - state encoding ST_IDLE=1'b0, ST_BURST=1'b1
- Natural sub-module: usr_bit_cell, one bit slice. It contains the next-value mux (self, left neighbour, right neighbour, D bit, reset bit) and a flop with sync reset and enable; instantiated WIDTH times with a generate loop.
- FSM and counter stay in the top module.

Test Plan:
- RESET_VAL=8'hA5; assert RST with EN=1, MODE=LOAD, D=8'hFF -> next edge Q=8'hA5, BUSY=0, DONE=0.
- LOAD 8'h81, then SHL with SIN_L=1 -> Q=8'h03, SOUT_L=0. Then SHR with SIN_R=1 -> Q=8'h81.
- LOAD 8'h81, ROR -> 8'hC0; ROL -> 8'h81. CLEAR -> Q=RESET_VAL.
- LOAD 8'h01, BURST AMT=3 -> BUSY high 3 cycles, Q: 02,04,08, DONE pulses with Q=8'h08. Repeat with EN low for 2 mid-burst cycles -> BUSY high 5 cycles, same final Q.
- BURST AMT=0 -> Q unchanged, BUSY never high, DONE 1 cycle. BURST AMT=9 (WIDTH=8) -> 1 rotate.
- Mid-burst RST -> Q=RESET_VAL, BUSY=0, no DONE. With USR_PARITY_EN: LOAD 8'h07 -> PAR=1; LOAD 8'h03 -> PAR=0.
